vga_plot_arbiter: RTL and testbench

Shares the single pixel-write port of the VGA adapter among up to NUM_REQ sprite drawers (spikes, player, background clear, score). Each drawer requests the port, receives a one-hot grant, and streams x/y/colour/plot through the arbiter. The arbiter applies round-robin fairness with a burst cap, so no drawer can starve the others. It sits between the sprite drawers' datapath/control pairs and the VGA adapter inputs.

---
 rtl/vga_arb_pkg.sv | 26 ++
 rtl/rr_picker.sv | 36 +++
 rtl/vga_plot_arbiter.sv | 176 +++++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_arb_pkg.sv
// Shared definitions for the VGA plot-port arbiter: FSM encoding, default widths
// and the ceiling-log2 helper used to size the index and burst counters.
package vga_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN     = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    localparam int DEF_X_W      = 8;
    localparam int DEF_Y_W      = 8;
    localparam int DEF_COLOUR_W = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: finds the first asserted request searching
// upward from last_winner+1 with wrap-around.
module rr_picker
    import vga_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_winner,
    output logic [NUM_REQ-1:0] winner_oh,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               found
);

    int cand;

    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        found      = 1'b0;
        cand       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_winner) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand]) begin
                found           = 1'b1;
                winner_idx      = IDX_W'(cand);
                winner_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the VGA adapter pixel-write port among NUM_REQ drawers with round-robin
// fairness and a per-grant burst cap. Define ARB_PRIO0_EN to give requester 0 priority.
module vga_plot_arbiter
    import vga_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int X_W       = DEF_X_W,
    parameter int Y_W       = DEF_Y_W,
    parameter int COLOUR_W  = DEF_COLOUR_W,
    parameter int MAX_BURST = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           done,
    input  logic [NUM_REQ*X_W-1:0]       req_x,
    input  logic [NUM_REQ*Y_W-1:0]       req_y,
    input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
    input  logic [NUM_REQ-1:0]           req_plot,
    output logic [NUM_REQ-1:0]           grant,
    output logic [X_W-1:0]               out_x,
    output logic [Y_W-1:0]               out_y,
    output logic [COLOUR_W-1:0]          out_colour,
    output logic                         plot,
    output logic                         busy
);

    localparam int IDX_W = clog2(NUM_REQ);
    localparam int CNT_W = clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

    arb_state_t            state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]      last_winner_q, last_winner_d;
    logic [CNT_W-1:0]      burst_cnt_q, burst_cnt_d;
    logic [X_W-1:0]        out_x_q, out_x_d;
    logic [Y_W-1:0]        out_y_q, out_y_d;
    logic [COLOUR_W-1:0]   out_colour_q, out_colour_d;
    logic                  plot_q, plot_d;
    logic                  busy_q, busy_d;

    logic [NUM_REQ-1:0]    pick_oh;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_found;
    logic [NUM_REQ-1:0]    sel_oh;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_found;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req         (req),
        .last_winner (last_winner_q),
        .winner_oh   (pick_oh),
        .winner_idx  (pick_idx),
        .found       (pick_found)
    );

`ifdef ARB_PRIO0_EN
    // Requester 0 pre-empts the rotation; the others still rotate via the picker.
    always_comb begin
        sel_oh    = pick_oh;
        sel_idx   = pick_idx;
        sel_found = pick_found;
        if (req[0]) begin
            sel_oh    = '0;
            sel_oh[0] = 1'b1;
            sel_idx   = '0;
            sel_found = 1'b1;
        end
    end
`else
    always_comb begin
        sel_oh    = pick_oh;
        sel_idx   = pick_idx;
        sel_found = pick_found;
    end
`endif

    // While owning, last_winner_q is the index of the granted requester.
    logic                own_req, own_plot, own_done;
    logic [X_W-1:0]      own_x;
    logic [Y_W-1:0]      own_y;
    logic [COLOUR_W-1:0] own_colour;

    always_comb begin
        own_req    = req[last_winner_q];
        own_plot   = req_plot[last_winner_q];
        own_done   = done[last_winner_q];
        own_x      = req_x[int'(last_winner_q)*X_W +: X_W];
        own_y      = req_y[int'(last_winner_q)*Y_W +: Y_W];
        own_colour = req_colour[int'(last_winner_q)*COLOUR_W +: COLOUR_W];
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_winner_d = last_winner_q;
        burst_cnt_d   = burst_cnt_q;
        out_x_d       = out_x_q;
        out_y_d       = out_y_q;
        out_colour_d  = out_colour_q;
        plot_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    grant_d       = sel_oh;
                    last_winner_d = sel_idx;
                    burst_cnt_d   = '0;
                    state_d       = ST_OWN;
                end
            end
            ST_OWN: begin
                if (!own_req) begin
                    grant_d = '0;
                    state_d = ST_RELEASE;
                end else begin
                    out_x_d      = own_x;
                    out_y_d      = own_y;
                    out_colour_d = own_colour;
                    if (own_plot) begin
                        plot_d      = 1'b1;
                        burst_cnt_d = burst_cnt_q + 1'b1;
                        if (own_done || (burst_cnt_q >= BURST_LAST)) begin
                            grant_d = '0;
                            state_d = ST_RELEASE;
                        end
                    end
                end
            end
            ST_RELEASE: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = |grant_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            last_winner_q <= LAST_IDX;
            burst_cnt_q   <= '0;
            out_x_q       <= '0;
            out_y_q       <= '0;
            out_colour_q  <= '0;
            plot_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_winner_q <= last_winner_d;
            burst_cnt_q   <= burst_cnt_d;
            out_x_q       <= out_x_d;
            out_y_q       <= out_y_d;
            out_colour_q  <= out_colour_d;
            plot_q        <= plot_d;
            busy_q        <= busy_d;
        end
    end

    assign grant      = grant_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_colour = out_colour_q;
    assign plot       = plot_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: stimulus pushes expected grants and pixels,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_vga_plot_arbiter;

    localparam int N  = 4;
    localparam int XW = 8;
    localparam int YW = 8;
    localparam int CW = 3;
    localparam int MB = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      req, done, req_plot;
    logic [N*XW-1:0]   req_x;
    logic [N*YW-1:0]   req_y;
    logic [N*CW-1:0]   req_colour;
    logic [N-1:0]      grant;
    logic [XW-1:0]     out_x;
    logic [YW-1:0]     out_y;
    logic [CW-1:0]     out_colour;
    logic              plot;
    logic              busy;

    always #5 clock = ~clock;

    vga_plot_arbiter #(
        .NUM_REQ   (N),
        .X_W       (XW),
        .Y_W       (YW),
        .COLOUR_W  (CW),
        .MAX_BURST (MB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .done       (done),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .req_plot   (req_plot),
        .grant      (grant),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_colour (out_colour),
        .plot       (plot),
        .busy       (busy)
    );

    typedef struct { int x; int y; int c; } pix_t;
    typedef struct { int idx; int gap; } gnt_t;

    pix_t exp_pix[$];
    gnt_t exp_gnt[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int oh2idx(input logic [N-1:0] v);
        int r;
        int cnt;
        r   = -1;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                r = i;
                cnt++;
            end
        end
        if (cnt != 1) r = -1;
        return r;
    endfunction

    task automatic push_pix(input int x, input int y, input int c);
        pix_t p;
        p.x = x; p.y = y; p.c = c;
        exp_pix.push_back(p);
    endtask

    task automatic push_gnt(input int idx, input int gap);
        gnt_t g;
        g.idx = idx; g.gap = gap;
        exp_gnt.push_back(g);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: pixels on plot, grant order and dead-cycle gap on each grant rise.
    logic [N-1:0] prev_grant = '0;
    int           gap_cnt    = 0;

    always @(negedge clock) begin
        pix_t p;
        gnt_t g;
        if (plot === 1'b1) begin
            if (exp_pix.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d, expected no plot",
                         out_x, out_y, out_colour);
            end else begin
                p = exp_pix.pop_front();
                chk("pix_x", int'(out_x), p.x);
                chk("pix_y", int'(out_y), p.y);
                chk("pix_colour", int'(out_colour), p.c);
            end
        end
        if (grant != '0 && prev_grant == '0) begin
            if (exp_gnt.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_grant: got %b, expected none", grant);
            end else begin
                g = exp_gnt.pop_front();
                chk("grant_idx", oh2idx(grant), g.idx);
                if (g.gap >= 0) chk("grant_gap", gap_cnt, g.gap);
                chk("busy_on_grant", int'(busy), 1);
            end
            gap_cnt = 0;
        end else if (grant == '0) begin
            gap_cnt++;
        end
        prev_grant = grant;
    end

    // One drawer: streams n pixels, holding the current one whenever not granted.
    task automatic draw(input int i, input int n, input int x0, input int y0,
                        input int col, input int idle_before);
        int k;
        int budget;
        bit idled;
        bit g;
        bit pl;
        k = 0; budget = 0; idled = 1'b0;
        req[i] = 1'b1;
        while (k < n) begin
            req_x[i*XW +: XW]      = XW'(x0 + k);
            req_y[i*YW +: YW]      = YW'(y0);
            req_colour[i*CW +: CW] = CW'(col);
            pl = !(k == idle_before && !idled);
            req_plot[i] = pl;
            done[i]     = (k == n - 1);
            g = grant[i];
            tick();
            if (g) begin
                if (pl) k++;
                else idled = 1'b1;
            end
            budget++;
            if (budget > 400) begin
                n_tests++;
                n_fail++;
                $display("FAIL draw_timeout_r%0d: got %0d pixels, expected %0d", i, k, n);
                break;
            end
        end
        req[i] = 1'b0; req_plot[i] = 1'b0; done[i] = 1'b0;
    endtask

    task automatic wait_grant(input int i);
        int budget;
        budget = 0;
        while (grant[i] !== 1'b1 && budget < 50) begin
            tick();
            budget++;
        end
        if (grant[i] !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_grant_r%0d: got grant=%b, expected bit %0d set", i, grant, i);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req = '0; done = '0; req_plot = '0;
        req_x = '0; req_y = '0; req_colour = '0;
        tick(); tick();
        chk("rst_grant", int'(grant), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_out_x", int'(out_x), 0);
        chk("rst_out_y", int'(out_y), 0);
        chk("rst_out_colour", int'(out_colour), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 1'b0;
        tick();

        // Single requester 2, three pixels
        push_gnt(2, -1);
        push_pix(10, 20, 5); push_pix(11, 20, 5); push_pix(12, 20, 5);
        draw(2, 3, 10, 20, 5, -1);
        chk("release_grant", int'(grant), 0);
        chk("release_last_plot", int'(plot), 1);
        chk("release_last_x", int'(out_x), 12);
        tick();
        chk("release_plot_low", int'(plot), 0);
        chk("release_busy_low", int'(busy), 0);
        repeat (4) tick();

        // Masking: requester 3 plots x=99 without req while requester 1 owns
        req_plot[3] = 1'b1; done[3] = 1'b1; req_x[3*XW +: XW] = 8'd99;
        push_gnt(1, -1);
        push_pix(30, 40, 6); push_pix(31, 40, 6); push_pix(32, 40, 6);
        draw(1, 3, 30, 40, 6, 2);
        repeat (4) tick();
        req_plot[3] = 1'b0; done[3] = 1'b0; req_x[3*XW +: XW] = '0;

        // Round-robin with all four requesting
        reset = 1'b1; tick(); reset = 1'b0; tick();
        push_gnt(0, -1); push_gnt(1, 2); push_gnt(2, 2); push_gnt(3, 2); push_gnt(0, 2);
        push_pix(50, 0, 0); push_pix(51, 1, 1); push_pix(52, 2, 2);
        push_pix(53, 3, 3); push_pix(54, 0, 0);
        fork
            begin draw(0, 1, 50, 0, 0, -1); draw(0, 1, 54, 0, 0, -1); end
            draw(1, 1, 51, 1, 1, -1);
            draw(2, 1, 52, 2, 2, -1);
            draw(3, 1, 53, 3, 3, -1);
        join
        repeat (4) tick();

        // Burst cap of 4 with requester 1 pending
        push_gnt(0, -1); push_gnt(1, 2); push_gnt(0, 2); push_gnt(0, 2);
        for (int k = 0; k < 4; k++) push_pix(100 + k, 1, 1);
        push_pix(200, 2, 2); push_pix(201, 2, 2);
        for (int k = 4; k < 10; k++) push_pix(100 + k, 1, 1);
        fork
            draw(0, 10, 100, 1, 1, -1);
            begin repeat (3) tick(); draw(1, 2, 200, 2, 2, -1); end
        join
        repeat (4) tick();

        // Requester 0 and 2 pending after requester 0's burst
`ifdef ARB_PRIO0_EN
        push_gnt(0, -1); push_gnt(0, 2); push_gnt(2, 2);
        push_pix(60, 5, 3); push_pix(61, 5, 3); push_pix(62, 6, 4);
`else
        push_gnt(0, -1); push_gnt(2, 2); push_gnt(0, 2);
        push_pix(60, 5, 3); push_pix(62, 6, 4); push_pix(61, 5, 3);
`endif
        fork
            begin draw(0, 1, 60, 5, 3, -1); draw(0, 1, 61, 5, 3, -1); end
            begin tick(); draw(2, 1, 62, 6, 4, -1); end
        join
        repeat (4) tick();

        // Reset while requester 1 is plotting x=5
        push_gnt(1, -1);
        req[1] = 1'b1;
        wait_grant(1);
        req_x[1*XW +: XW] = 8'd5; req_plot[1] = 1'b1;
        @(posedge clock);
        #2;
        chk("pre_reset_plot", int'(plot), 1);
        chk("pre_reset_out_x", int'(out_x), 5);
        reset = 1'b1;
        #1;
        chk("mid_reset_grant", int'(grant), 0);
        chk("mid_reset_plot", int'(plot), 0);
        chk("mid_reset_out_x", int'(out_x), 0);
        chk("mid_reset_busy", int'(busy), 0);
        req_plot = '0; req_x = '0; req = 4'b0011;
        tick(); tick();
        push_gnt(0, -1); push_gnt(1, 2);
        reset = 1'b0;
        wait_grant(0);
        req[0] = 1'b0;
        wait_grant(1);
        req[1] = 1'b0;
        repeat (6) tick();

        chk("pix_queue_left", exp_pix.size(), 0);
        chk("gnt_queue_left", exp_gnt.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
